// File: rtl/beat_step_sequencer.sv
// beat_step_sequencer
//
// Purpose: steps through a programmable drum pattern, one step per beat
// tick. Each fired step emits a TRIG_LEN-cycle trigger on every channel whose
// pattern bit is set, reports the step index, and flags bar starts (step 0).
// New patterns are accepted into a shadow register and are promoted to the
// active pattern only at a bar boundary, or at once while stopped, so a bar
// never plays with a mix of two patterns.
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   reset      synchronous, active-high; clears all state
//   beat       single-cycle tick from the beat generator
//   run        level; 1 = play, 0 = stop
//   pat_valid  new pattern offered
//   pat_data   pattern; bit [c*STEPS+s] = channel c fires on step s
//   pat_ready  sequencer can accept a pattern
//   trig       per-channel trigger pulses
//   step       index of the most recently fired step
//   bar_start  one-cycle flag, step 0 fired
//   busy       high in ARMED or PLAY
//
// Handshake: a pattern transfers on any rising edge where pat_valid and
// pat_ready are both high. pat_ready is registered and stays low while a
// transferred pattern waits for its bar boundary, so a held pat_valid stalls.
module beat_step_sequencer #(
  parameter int STEPS    = 16,
  parameter int CH       = 2,
  parameter int TRIG_LEN = 4,
  parameter int SW       = $clog2(STEPS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                beat,
  input  logic                run,
  input  logic                pat_valid,
  input  logic [CH*STEPS-1:0] pat_data,
  output logic                pat_ready,
  output logic [CH-1:0]       trig,
  output logic [SW-1:0]       step,
  output logic                bar_start,
  output logic                busy
);

  localparam int CW = $clog2(TRIG_LEN + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    PLAY  = 2'd2
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [CH*STEPS-1:0] active;
  logic [CH*STEPS-1:0] shadow;
  logic                pending;
  logic                pending_next;
  logic [SW-1:0]       cur;
  logic [CW-1:0]       cnt;

  logic                fire;
  logic [SW-1:0]       fire_step;
  logic                swap_bar;
  logic                swap_idle;
  logic                xfer;
  logic [CH*STEPS-1:0] fire_pat;
  logic [CH-1:0]       fire_bits;

  // Next-state and fire decode. ARMED always plays step 0 first, so a
  // restart after a stop begins a fresh bar.
  always_comb begin
    state_next = state;
    fire       = 1'b0;
    fire_step  = '0;
    case (state)
      IDLE: begin
        if (run) state_next = ARMED;
      end
      ARMED: begin
        if (!run) begin
          state_next = IDLE;
        end else if (beat) begin
          fire       = 1'b1;
          fire_step  = '0;
          state_next = PLAY;
        end
      end
      PLAY: begin
        if (!run) begin
          state_next = IDLE;
        end else if (beat) begin
          fire      = 1'b1;
          fire_step = cur;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Pattern selection: a step-0 fire with a pending pattern plays the shadow
  // directly so the new bar starts on the new pattern in the same edge.
  always_comb begin
    xfer         = pat_valid && pat_ready;
    swap_bar     = fire && (fire_step == '0) && pending;
    swap_idle    = (state == IDLE) && pending;
    fire_pat     = swap_bar ? shadow : active;
    pending_next = xfer || (pending && !swap_bar && !swap_idle);
    fire_bits    = '0;
    for (int c = 0; c < CH; c++) begin
      fire_bits[c] = fire_pat[c*STEPS + int'(fire_step)];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      active    <= '0;
      shadow    <= '0;
      pending   <= 1'b0;
      pat_ready <= 1'b1;
      cur       <= '0;
      cnt       <= '0;
      trig      <= '0;
      step      <= '0;
      bar_start <= 1'b0;
    end else begin
      state     <= state_next;
      busy      <= (state_next != IDLE);
      pending   <= pending_next;
      pat_ready <= !pending_next;
      bar_start <= fire && (fire_step == '0);

      if (xfer) shadow <= pat_data;
      if (swap_bar || swap_idle) active <= shadow;

      // Stop truncates any trigger in flight; step is left as a record of
      // the last step played.
      if (!run) begin
        cur  <= '0;
        cnt  <= '0;
        trig <= '0;
      end else if (fire) begin
        trig <= fire_bits;
        step <= fire_step;
        cur  <= fire_step + 1'b1;
        cnt  <= CW'(TRIG_LEN);
      end else if (cnt != '0) begin
        cnt <= cnt - 1'b1;
        if (cnt == CW'(1)) trig <= '0;
      end
    end
  end

endmodule

// File: tb/tb_beat_step_sequencer.sv
// Self-checking bench for beat_step_sequencer with a bar-level reference model.
module tb_beat_step_sequencer;

  localparam int STEPS    = 16;
  localparam int CH       = 2;
  localparam int TRIG_LEN = 4;
  localparam int SW       = 4;
  localparam int PW       = CH * STEPS;
  localparam int VW       = CH + SW + 3;
  localparam logic [VW-1:0] RST_VEC = VW'(1);

  // ---------------- clock / reset ----------------
  logic          clk;
  logic          reset;
  logic          beat;
  logic          run;
  logic          pat_valid;
  logic [PW-1:0] pat_data;
  logic          pat_ready;
  logic [CH-1:0] trig;
  logic [SW-1:0] step;
  logic          bar_start;
  logic          busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  beat_step_sequencer #(
    .STEPS(STEPS), .CH(CH), .TRIG_LEN(TRIG_LEN)
  ) dut (
    .clk(clk), .reset(reset), .beat(beat), .run(run),
    .pat_valid(pat_valid), .pat_data(pat_data), .pat_ready(pat_ready),
    .trig(trig), .step(step), .bar_start(bar_start), .busy(busy)
  );

  int tests = 0;
  int fails = 0;

  // ---------------- reference model ----------------
  // Mode: 0 stopped, 1 waiting for first beat, 2 playing.
  int            m_mode;
  int            m_next;
  int            m_left;
  int            m_s;
  logic [PW-1:0] m_active;
  logic [PW-1:0] m_shadow;
  bit            m_pend;
  bit            m_acc;
  bit            m_was_stopped;
  logic [CH-1:0] m_held;
  logic [SW-1:0] e_step;
  bit            e_bar;
  bit            e_ready;

  logic [VW-1:0] exp_q[$];
  logic [VW-1:0] exp_now;
  logic [VW-1:0] act;

  task automatic model_step();
    logic [CH-1:0] t;
    if (reset) begin
      m_mode = 0; m_next = 0; m_left = 0; m_active = '0; m_shadow = '0;
      m_pend = 0; m_held = '0; e_step = '0; e_bar = 0; e_ready = 1;
    end else begin
      m_acc = pat_valid && e_ready;
      m_was_stopped = (m_mode == 0);
      e_bar = 0;
      if (!run) begin
        m_mode = 0; m_next = 0; m_left = 0;
      end else if (m_was_stopped) begin
        m_mode = 1;
      end else if (beat) begin
        m_s = (m_mode == 1) ? 0 : m_next;
        if (m_s == 0 && m_pend) begin m_active = m_shadow; m_pend = 0; end
        for (int c = 0; c < CH; c++) m_held[c] = m_active[c*STEPS + m_s];
        m_left = TRIG_LEN;
        e_step = SW'(m_s);
        e_bar = (m_s == 0);
        m_next = (m_s + 1) % STEPS;
        m_mode = 2;
      end else if (m_left > 0) begin
        m_left = m_left - 1;
      end
      if (m_was_stopped && m_pend) begin m_active = m_shadow; m_pend = 0; end
      if (m_acc) begin m_shadow = pat_data; m_pend = 1; end
      e_ready = !m_pend;
    end
    t = (m_left > 0) ? m_held : '0;
    exp_q.push_back({t, e_step, e_bar, (m_mode != 0), e_ready});
  endtask

  // ---------------- driver ----------------
  task automatic tick(input logic b, input logic r, input logic v, input logic [PW-1:0] d);
    beat = b; run = r; pat_valid = v; pat_data = d;
    model_step();
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) exp_now = 'x;
    else exp_now = exp_q.pop_front();
    act = {trig, step, bar_start, busy, pat_ready};
  endtask

  function automatic logic [PW-1:0] rand_pat();
    logic [PW-1:0] d;
    for (int i = 0; i < PW; i++) d[i] = 1'($urandom_range(0, 1));
    return d;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick(1'b0, 1'b0, 1'b0, '0);
    tests++;
    if (act !== RST_VEC) begin
      fails++; $display("FAIL reset_hold: got %h want %h", act, RST_VEC);
    end
    reset = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick((i % 20) == 19, 1'b0, 1'b0, '0);
      tests++;
      if (act !== RST_VEC || act !== exp_now) begin
        fails++; $display("FAIL idle_beats cyc %0d: got %h want %h", i, act, RST_VEC);
      end
    end
  endtask

  task automatic test_basic_play();
    int hi0 = 0, hi1 = 0, bars = 0;
    tick(1'b0, 1'b0, 1'b1, {16'h0101, 16'h1111});
    tick(1'b0, 1'b0, 1'b0, '0);
    tick(1'b0, 1'b1, 1'b0, '0);
    for (int b = 0; b < 17; b++) begin
      for (int k = 0; k < 20; k++) begin
        tick(k == 0, 1'b1, 1'b0, '0);
        tests++;
        if (act !== exp_now) begin
          fails++; $display("FAIL basic_model b%0d k%0d: got %h want %h", b, k, act, exp_now);
        end
        if (trig[0]) hi0++;
        if (trig[1]) hi1++;
        if (bar_start) bars++;
        if (k == 0) begin
          tests++;
          if (step !== SW'(b % STEPS)) begin
            fails++; $display("FAIL basic_step b%0d: got %0d want %0d", b, step, b % STEPS);
          end
        end
      end
    end
    tests++;
    if (hi0 != 20 || hi1 != 12 || bars != 2) begin
      fails++; $display("FAIL basic_counts: got ch0=%0d ch1=%0d bars=%0d want 20 12 2", hi0, hi1, bars);
    end
    tick(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic test_retrigger();
    int hi = 0;
    tick(1'b0, 1'b0, 1'b1, '1);
    tick(1'b0, 1'b0, 1'b0, '0);
    tick(1'b0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 30; i++) begin
      tick((i < 20) && (i % 2 == 0), 1'b1, 1'b0, '0);
      tests++;
      if (act !== exp_now) begin
        fails++; $display("FAIL retrig_model i%0d: got %h want %h", i, act, exp_now);
      end
      if (trig == '1) hi++;
      tests++;
      if ((i < 22) !== (trig == '1)) begin
        fails++; $display("FAIL retrig_level i%0d: got trig=%b want high=%0d", i, trig, i < 22);
      end
    end
    tests++;
    if (hi != 22) begin
      fails++; $display("FAIL retrig_width: got %0d want 22", hi);
    end
    tick(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic test_bar_swap();
    logic [PW-1:0] old_pat;
    logic [PW-1:0] new_pat;
    old_pat = {16'($urandom), 16'hFFFF};
    new_pat = {16'h0000, 16'h0001};
    tick(1'b0, 1'b0, 1'b1, old_pat);
    tick(1'b0, 1'b0, 1'b0, '0);
    tick(1'b0, 1'b1, 1'b0, '0);
    for (int b = 0; b < 18; b++) begin
      for (int k = 0; k < 6; k++) begin
        tick(k == 0, 1'b1, (b == 5) && (k == 1), new_pat);
        tests++;
        if (act !== exp_now) begin
          fails++; $display("FAIL swap_model b%0d k%0d: got %h want %h", b, k, act, exp_now);
        end
        if (b == 5 && k == 1) begin
          tests++;
          if (pat_ready !== 1'b0) begin
            fails++; $display("FAIL swap_ready_drop: got %b want 0", pat_ready);
          end
        end
        if (b >= 6 && b <= 15 && k == 0) begin
          tests++;
          if (trig[0] !== 1'b1 || pat_ready !== 1'b0) begin
            fails++; $display("FAIL swap_old b%0d: got trig0=%b ready=%b want 1 0", b, trig[0], pat_ready);
          end
        end
        if (b == 16 && k == 0) begin
          tests++;
          if (trig !== 2'b01 || pat_ready !== 1'b1 || bar_start !== 1'b1) begin
            fails++; $display("FAIL swap_new: got trig=%b ready=%b bar=%b want 01 1 1", trig, pat_ready, bar_start);
          end
        end
        if (b == 17 && k == 0) begin
          tests++;
          if (trig !== 2'b00) begin
            fails++; $display("FAIL swap_step1: got %b want 00", trig);
          end
        end
      end
    end
    tick(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic test_stop_restart();
    tick(1'b0, 1'b0, 1'b1, {16'($urandom), 16'h0080 | 16'($urandom)});
    tick(1'b0, 1'b0, 1'b0, '0);
    tick(1'b0, 1'b1, 1'b0, '0);
    for (int b = 0; b < 7; b++)
      for (int k = 0; k < 6; k++) begin
        tick(k == 0, 1'b1, 1'b0, '0);
        tests++;
        if (act !== exp_now) begin
          fails++; $display("FAIL stop_model b%0d k%0d: got %h want %h", b, k, act, exp_now);
        end
      end
    tick(1'b1, 1'b1, 1'b0, '0);
    tests++;
    if (trig[0] !== 1'b1 || step !== SW'(7)) begin
      fails++; $display("FAIL stop_step7: got trig0=%b step=%0d want 1 7", trig[0], step);
    end
    tick(1'b0, 1'b0, 1'b0, '0);
    tests++;
    if (trig !== '0 || busy !== 1'b0 || step !== SW'(7) || act !== exp_now) begin
      fails++; $display("FAIL stop_drop: got trig=%b busy=%b step=%0d want 0 0 7", trig, busy, step);
    end
    tick(1'b1, 1'b0, 1'b0, '0);
    tests++;
    if (busy !== 1'b0 || bar_start !== 1'b0 || step !== SW'(7)) begin
      fails++; $display("FAIL stop_beat_ignored: got busy=%b bar=%b step=%0d want 0 0 7", busy, bar_start, step);
    end
    tick(1'b0, 1'b1, 1'b0, '0);
    tick(1'b1, 1'b1, 1'b0, '0);
    tests++;
    if (step !== '0 || bar_start !== 1'b1 || busy !== 1'b1 || act !== exp_now) begin
      fails++; $display("FAIL restart: got step=%0d bar=%b busy=%b want 0 1 1", step, bar_start, busy);
    end
  endtask

  task automatic test_reset_mid();
    tick(1'b0, 1'b1, 1'b1, '1);
    tests++;
    if (pat_ready !== 1'b0) begin
      fails++; $display("FAIL rstmid_pending: got ready=%b want 0", pat_ready);
    end
    reset = 1'b1;
    tick(1'b0, 1'b1, 1'b0, '0);
    reset = 1'b0;
    tests++;
    if (act !== RST_VEC) begin
      fails++; $display("FAIL rstmid_values: got %h want %h", act, RST_VEC);
    end
    tick(1'b0, 1'b1, 1'b0, '0);
    for (int b = 0; b < 17; b++)
      for (int k = 0; k < 6; k++) begin
        tick(k == 0, 1'b1, 1'b0, '0);
        tests++;
        if (trig !== '0 || act !== exp_now) begin
          fails++; $display("FAIL rstmid_silent b%0d k%0d: got %h want %h", b, k, act, exp_now);
        end
      end
    tick(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 499) == 0);
      tick($urandom_range(0, 3) == 0, $urandom_range(0, 19) != 0,
           $urandom_range(0, 7) == 0, rand_pat());
      tests++;
      if (act !== exp_now) begin
        fails++; $display("FAIL random cyc %0d: got %h want %h", i, act, exp_now);
      end
    end
    reset = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1; beat = 1'b0; run = 1'b0; pat_valid = 1'b0; pat_data = '0;
    test_reset();
    test_basic_play();
    test_retrigger();
    test_bar_swap();
    test_stop_restart();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule

// File: doc/beat_step_sequencer.md
Name: beat_step_sequencer

Overview:
- Downstream consumer of the beat generator's single-cycle `pulse` output.
- On each beat it advances through a programmable step pattern and emits fixed-length drum trigger pulses on CH channels.
- It also flags bar boundaries.
- Patterns load through a valid/ready handshake and take effect only on a bar boundary, so playback never glitches mid-bar.

Parameters:
STEPS, 16, steps per bar (power of two, >= 2)
CH, 2, number of trigger channels
TRIG_LEN, 4, trigger high time in clk cycles (>= 1, < minimum beat spacing)
SW, $clog2(STEPS), step index width (derived, not overridden)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high; clears all state
beat  input  1  single-cycle tick from beat generator `pulse`
run  input  1  level; 1 = play, 0 = stop
pat_valid  input  1  new pattern offered
pat_data  input  CH*STEPS  pattern; bit [c*STEPS+s] = channel c fires on step s
pat_ready  output  1  sequencer can accept a pattern
trig  output  CH  per-channel trigger pulses
step  output  SW  index of most recently fired step
bar_start  output  1  one-cycle flag, step 0 fired
busy  output  1  high in ARMED or PLAY

Behaviour:
- Reset values: trig=0, step=0, bar_start=0, busy=0, pat_ready=1, active pattern=0, pending flag=0, cur=0, trigger counter=0, state=IDLE.
- States:
  - IDLE: run=1 -> ARMED.
  - ARMED: run=0 -> IDLE. A beat with run=1 fires step 0 -> PLAY.
  - PLAY: run=0 -> IDLE. A beat fires step `cur`.
- busy = (state != IDLE), registered with state.
- Firing step s on a beat at edge N (all outputs registered):
  - From edge N+1: trig = active_pattern bits for step s across all channels; step = s; bar_start = (s==0) for exactly one cycle.
  - cur <= s+1 modulo STEPS; STEPS-1 wraps to 0.
- Trigger length:
  - Counter loads TRIG_LEN on each fire; trig is high exactly TRIG_LEN cycles, then returns to 0.
  - A new beat while trig is active reloads trig from the new step and restarts the count.
  - A channel whose bit is 0 in the new step drops on that edge.
- Latency beat->trig is 1 cycle. Beats in IDLE are ignored.
- Stop: run=0 seen at an edge gives:
  - state IDLE, cur=0, trig=0 and counter=0 (truncated) on that edge;
  - step and the active pattern are retained.
- A beat coincident with run=0 is ignored.
- Pattern handshake:
  - Transfer when pat_valid && pat_ready; data goes to the shadow register and pending is set.
  - pat_ready = ~pending, registered.
  - In IDLE with pending=1: active <= shadow on the next edge; pending clears.
  - In ARMED/PLAY: the swap occurs at the edge of a beat that fires step 0; that step 0 already uses the new pattern (combinational select of shadow for the fire).
  - A transfer on the same edge as a step-0 fire becomes pending and applies at the next bar.
  - While pending=1, pat_ready=0 and further offers stall.
- Reset mid-operation: all of the above return to reset values on the edge; the pending pattern is discarded.
- run may toggle at any time. Re-entering ARMED always restarts at step 0.

Test Plan:
- Reset/idle: reset held 3 cycles, beats every 20 cycles, run=0 -> trig=0, busy=0, step=0, pat_ready=1, no bar_start.
- Basic play: load pat_data with ch0=16'h1111, ch1=16'h0101 in IDLE, run=1, beats every 20 cycles ->
  - ch0 trig 4 cycles wide on steps 0,4,8,12;
  - ch1 on steps 0,8;
  - bar_start on the first beat and on every 16th beat;
  - step counts 0..15 then 0.
- Retrigger: TRIG_LEN=4, beats 2 cycles apart, pattern all ones -> trig stays high continuously and falls 4 cycles after the final beat.
- Bar-aligned swap: during step 5, offer ch0=16'h0001 ->
  - pat_ready drops the next cycle;
  - steps 6..15 still use the old pattern;
  - step 0 uses the new one;
  - pat_ready returns the cycle after the step-0 fire.
- Stop/restart: drop run while trig is high at step 7 -> trig=0 and busy=0 on the next edge; raise run -> the first beat fires step 0 with bar_start=1.
- Reset mid-play with a pattern pending -> all outputs at reset values next cycle; active pattern=0, so no triggers after re-run until a new load.
